// File: rtl/ds_sample_feeder.sv
// Sample FIFO and pulse-rate pacer feeding the delta-sigma modulator input.
// One sample is released every rate_div+1 completed PWM pulses; underrun/overflow are sticky.
module ds_sample_feeder #(
    parameter int DEPTH    = 8,
    parameter int WIDTH    = 16,
    parameter int DIV_BITS = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_valid,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       wr_ready,
    input  logic                       flush,
    input  logic                       enable,
    input  logic                       pulse_done,
    input  logic [DIV_BITS-1:0]        rate_div,
    input  logic                       underrun_mode,
    input  logic                       clear_flags,
    output logic [WIDTH-1:0]           sample_out,
    output logic                       sample_strobe,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       underrun_flag,
    output logic                       overflow_flag
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] MIDSCALE = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [AW:0]         wptr, rptr;
    logic [DIV_BITS-1:0] div_cnt;
    logic                full, empty, tick, push, pop, underrun, overflow;

    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign level    = wptr - rptr;
    assign wr_ready = !full;

    assign tick     = enable && pulse_done && (div_cnt == '0);
    assign push     = wr_valid && !full && !flush;
    // A flush empties the FIFO this cycle, so a coincident tick must underrun.
    assign pop      = tick && !empty && !flush;
    assign underrun = tick && (empty || flush);
    assign overflow = wr_valid && full;

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (flush)
                rptr <= wptr;
            else if (pop)
                rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            div_cnt <= '0;
        else if (!enable)
            div_cnt <= '0;
        else if (pulse_done)
            div_cnt <= (div_cnt == '0) ? rate_div : div_cnt - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_out    <= MIDSCALE;
            sample_strobe <= 1'b0;
        end else begin
            sample_strobe <= tick;
            if (pop)
                sample_out <= mem[rptr[AW-1:0]];
            else if (underrun && underrun_mode)
                sample_out <= MIDSCALE;
        end
    end

    // Set events take priority over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            underrun_flag <= 1'b0;
            overflow_flag <= 1'b0;
        end else begin
            if (underrun)
                underrun_flag <= 1'b1;
            else if (clear_flags)
                underrun_flag <= 1'b0;
            if (overflow)
                overflow_flag <= 1'b1;
            else if (clear_flags)
                overflow_flag <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ds_sample_feeder.sv
// Directed bench for ds_sample_feeder: reset, play-out, overflow, underrun, simultaneous events, flush/wrap.
module tb_ds_sample_feeder;
    logic        clk = 1'b0;
    logic        reset;
    logic        wr_valid;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic        flush;
    logic        enable;
    logic        pulse_done;
    logic [7:0]  rate_div;
    logic        underrun_mode;
    logic        clear_flags;
    logic [15:0] sample_out;
    logic        sample_strobe;
    logic [3:0]  level;
    logic        underrun_flag;
    logic        overflow_flag;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] ev;

    ds_sample_feeder #(.DEPTH(8), .WIDTH(16), .DIV_BITS(8)) dut (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .flush(flush), .enable(enable), .pulse_done(pulse_done),
        .rate_div(rate_div), .underrun_mode(underrun_mode), .clear_flags(clear_flags),
        .sample_out(sample_out), .sample_strobe(sample_strobe), .level(level),
        .underrun_flag(underrun_flag), .overflow_flag(overflow_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] v);
        wr_valid = 1'b1;
        wr_data  = v;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic pulse();
        pulse_done = 1'b1;
        step();
        pulse_done = 1'b0;
    endtask

    task automatic clr();
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr_valid = 0; wr_data = '0; flush = 0; enable = 0;
        pulse_done = 0; rate_div = '0; underrun_mode = 0; clear_flags = 0;
        step(); step();
        reset = 1'b0;
        step();

        // Reset state, and no strobes while disabled
        chk("rst_sample", sample_out, 16'h8000);
        chk("rst_level", level, 4'd0);
        chk("rst_wr_ready", wr_ready, 1'b1);
        chk("rst_uflag", underrun_flag, 1'b0);
        chk("rst_oflag", overflow_flag, 1'b0);
        chk("rst_strobe", sample_strobe, 1'b0);
        for (int i = 0; i < 3; i++) begin
            pulse();
            chk("dis_strobe", sample_strobe, 1'b0);
        end

        // Basic play-out, rate_div=2: ticks on pulses 1, 4, 7
        rate_div = 8'd2;
        push(16'h1234); push(16'h5678); push(16'h9ABC);
        chk("basic_level3", level, 4'd3);
        enable = 1'b1;
        for (int p = 1; p <= 7; p++) begin
            pulse();
            chk("basic_strobe", sample_strobe, (p == 1 || p == 4 || p == 7));
            if (p == 1) begin chk("basic_s1", sample_out, 16'h1234); chk("basic_l2", level, 4'd2); end
            if (p == 4) begin chk("basic_s2", sample_out, 16'h5678); chk("basic_l1", level, 4'd1); end
            if (p == 7) begin chk("basic_s3", sample_out, 16'h9ABC); chk("basic_l0", level, 4'd0); end
        end
        step();
        chk("strobe_one_cycle", sample_strobe, 1'b0);
        chk("basic_no_uflag", underrun_flag, 1'b0);
        enable = 1'b0;

        // Overflow: 9 pushes into depth 8
        for (int i = 0; i < 9; i++) push(16'h0100 + 16'(i));
        chk("ovf_level", level, 4'd8);
        chk("ovf_wr_ready", wr_ready, 1'b0);
        chk("ovf_flag", overflow_flag, 1'b1);
        clr();
        chk("ovf_clear", overflow_flag, 1'b0);
        rate_div = 8'd0;
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pulse();
            chk("ovf_play", sample_out, 16'h0100 + 16'(i));
        end
        chk("ovf_drained", level, 4'd0);
        chk("ovf_no_uflag", underrun_flag, 1'b0);

        // Underrun, hold mode then midscale mode
        push(16'h4000);
        pulse();
        chk("und_load", sample_out, 16'h4000);
        underrun_mode = 1'b0;
        pulse();
        chk("und_hold_strobe", sample_strobe, 1'b1);
        chk("und_hold", sample_out, 16'h4000);
        chk("und_flag0", underrun_flag, 1'b1);
        clr();
        chk("und_clear", underrun_flag, 1'b0);
        underrun_mode = 1'b1;
        pulse();
        chk("und_mid", sample_out, 16'h8000);
        chk("und_flag1", underrun_flag, 1'b1);
        clr();

        // Clear loses to a same-cycle underrun
        clear_flags = 1'b1; pulse_done = 1'b1;
        step();
        clear_flags = 1'b0; pulse_done = 1'b0;
        chk("set_beats_clear", underrun_flag, 1'b1);
        clr();
        underrun_mode = 1'b0;

        // Push and tick together on an empty FIFO
        wr_valid = 1'b1; wr_data = 16'h2222; pulse_done = 1'b1;
        step();
        wr_valid = 1'b0; pulse_done = 1'b0;
        chk("sim_empty_strobe", sample_strobe, 1'b1);
        chk("sim_empty_uflag", underrun_flag, 1'b1);
        chk("sim_empty_level", level, 4'd1);
        chk("sim_empty_hold", sample_out, 16'h8000);
        pulse();
        chk("sim_empty_next", sample_out, 16'h2222);
        clr();

        // Push and tick together at level 4
        for (int i = 0; i < 4; i++) push(16'h0031 + 16'(i));
        chk("sim4_pre", level, 4'd4);
        wr_valid = 1'b1; wr_data = 16'h0035; pulse_done = 1'b1;
        step();
        wr_valid = 1'b0; pulse_done = 1'b0;
        chk("sim4_level", level, 4'd4);
        chk("sim4_sample", sample_out, 16'h0031);
        for (int i = 0; i < 4; i++) begin
            pulse();
            chk("sim4_drain", sample_out, 16'h0032 + 16'(i));
        end
        chk("sim4_no_uflag", underrun_flag, 1'b0);

        // Stream 20 samples across the pointer wrap
        for (int i = 0; i < 20; i++) begin
            push(16'h5000 + 16'(i));
            exp_q.push_back(16'h5000 + 16'(i));
            if (i >= 3) begin
                pulse();
                ev = exp_q.pop_front();
                chk("wrap_data", sample_out, ev);
            end
        end
        while (exp_q.size() > 0) begin
            pulse();
            ev = exp_q.pop_front();
            chk("wrap_tail", sample_out, ev);
        end
        chk("wrap_level", level, 4'd0);
        chk("wrap_no_uflag", underrun_flag, 1'b0);

        // Flush with a same-cycle push
        enable = 1'b0;
        push(16'hA001); push(16'hA002); push(16'hA003);
        chk("fl_pre", level, 4'd3);
        flush = 1'b1; wr_valid = 1'b1; wr_data = 16'hA004;
        step();
        flush = 1'b0; wr_valid = 1'b0;
        chk("fl_level", level, 4'd0);
        chk("fl_keep_sample", sample_out, 16'h5013);
        enable = 1'b1;
        pulse();
        chk("fl_strobe", sample_strobe, 1'b1);
        chk("fl_uflag", underrun_flag, 1'b1);
        chk("fl_hold", sample_out, 16'h5013);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ds_sample_feeder.md
# ds_sample_feeder

Sample buffer and rate pacer in front of the delta-sigma pulse-width modulator. It stores 16-bit samples written by the host byte interface in a small FIFO and releases one sample to the modulator input every `rate_div+1` completed pulses, so audio-rate streams play out at a steady rate without per-sample host timing. Underruns and overflows are flagged sticky for the host to poll.

## Interface
Parameters:
- `DEPTH`, 8: FIFO depth in samples; power of two, at least 2.
- `WIDTH`, 16: sample width.
- `DIV_BITS`, 8: width of the pulse-rate divider.

Ports. Clock `clk`; reset `reset`, synchronous, active-high.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `wr_valid` in 1: single-cycle write strobe from the register interface.
- `wr_data` in WIDTH: sample to push.
- `wr_ready` out 1: `!full`; status only.
- `flush` in 1: empty the FIFO.
- `enable` in 1: playback enable.
- `pulse_done` in 1: one-cycle pulse from the modulator at each completed PWM period.
- `rate_div` in DIV_BITS: pop one sample every `rate_div+1` pulses.
- `underrun_mode` in 1: 0 = hold last sample on underrun; 1 = output midscale `1<<(WIDTH-1)`.
- `clear_flags` in 1: clear both sticky flags.
- `sample_out` out WIDTH: registered modulator input.
- `sample_strobe` out 1: one-cycle pulse when `sample_out` is (re)loaded.
- `level` out $clog2(DEPTH)+1: number of stored samples.
- `underrun_flag` out 1: sticky.
- `overflow_flag` out 1: sticky.

## Operation
- **Storage.** FIFO with read and write pointers of $clog2(DEPTH)+1 bits each, with the wrap bit included.
  - `full` = pointers equal except for the MSB.
  - `empty` = pointers fully equal.
  - `level` = `wptr - rptr`, registered via the pointers.
- **Push.** `wr_valid && !full && !flush` writes `wr_data` and increments `wptr`.
  - `wr_valid && full` drops the data and sets `overflow_flag`.
  - This holds even if a pop occurs in the same cycle; there is no full-bypass.
- **Divider.** `div_cnt` has DIV_BITS bits.
  - While `!enable`, `div_cnt <= 0`.
  - When enabled and `pulse_done`:
    - if `div_cnt == 0`, tick and set `div_cnt <= rate_div`;
    - otherwise `div_cnt <= div_cnt - 1`.
  - The first `pulse_done` after enable therefore ticks immediately.
  - A `rate_div` change takes effect at the next reload.
- **Tick.**
  - If not empty: `sample_out <= mem[rptr]`, increment `rptr`, assert `sample_strobe`.
  - If empty: set `underrun_flag`, assert `sample_strobe`, and either hold `sample_out` (`underrun_mode=0`) or load midscale (`underrun_mode=1`).
- **Simultaneous push and tick on an empty FIFO.** The push is stored and the tick underruns; there is no write-through bypass.
- **Simultaneous push and tick on a non-empty, non-full FIFO.** Both occur, and `level` is unchanged.
- **Flush.** `rptr <= wptr`, and any same-cycle push is discarded. A same-cycle tick is treated as on an empty FIFO.
  - Flush does not clear flags or `sample_out`.
- **Clearing flags.**
  - `clear_flags` clears both sticky flags.
  - A set event in the same cycle wins.
- **Reset values:**
  - pointers 0;
  - `level` 0;
  - `wr_ready` 1;
  - `sample_out` = `1<<(WIDTH-1)` (0x8000);
  - `sample_strobe` 0;
  - both flags 0;
  - `div_cnt` 0.
- **Reset mid-stream.** FIFO contents are discarded. Memory contents need no reset.

## Timing
- **Write latency.** A sample written in cycle N is counted in `level` at N+1 and is poppable by a tick at N+1 or later.
- **Output latency.**
  - `sample_out` and `sample_strobe` update in the cycle after the `pulse_done` that ticks.
  - The modulator samples `u` on a later pulse boundary, so one cycle of latency is acceptable.
- **Strobe timing.** `sample_strobe` is high for exactly one cycle per tick. Ticks are separated by at least `rate_div+1` `pulse_done` events.
- **Status outputs.**
  - Flags become visible the cycle after the causing event.
  - `wr_ready` is combinational from the registered pointers.
- **No combinational path** from `wr_valid` or `pulse_done` to any output.

## Test plan
- **Reset state.** Assert reset and release. Require:
  - `sample_out` = 0x8000;
  - `level` = 0;
  - `wr_ready` = 1;
  - flags 0;
  - no `sample_strobe` while `enable` = 0, even with `pulse_done` toggling.
- **Basic play-out.** Push 0x1234, 0x5678, 0x9ABC with `rate_div` = 2 and `enable` = 1, then pulse `pulse_done` 7 times. Require:
  - strobes after pulses 1, 4 and 7;
  - `sample_out` sequence 0x1234, 0x5678, 0x9ABC;
  - `level` 3→2→1→0.
- **Overflow.** With `DEPTH` = 8, push 9 samples with `enable` = 0. Require:
  - `level` = 8 and `wr_ready` = 0;
  - `overflow_flag` = 1;
  - the 9th sample is absent on play-out;
  - `clear_flags` returns the flag to 0.
- **Underrun.** With an empty FIFO and `rate_div` = 0:
  - with `underrun_mode` = 0 and last sample 0x4000: a tick holds 0x4000 and sets `underrun_flag`;
  - repeat with `underrun_mode` = 1: `sample_out` becomes 0x8000.
- **Simultaneous events.**
  - Push on an empty FIFO in the same cycle as a tick: underrun flagged, `level` = 1 afterwards, and the next tick outputs the pushed value.
  - With `level` = 4, push and tick together: `level` stays 4.
- **Flush and wrap-around.**
  - Stream 20 samples through `DEPTH` = 8 with interleaved pushes and pops. Require data order preserved across pointer wrap.
  - Then push 3 and flush with a push in the same cycle. Require `level` = 0 and the next tick underruns.
